// File: rtl/vip_dataflow_if.sv
// Handshake bundle between the dataflow controller and its three stages
// (video input, processing loop, video output) plus the top-level handshake.
interface vip_dataflow_if;
    // top-level block handshake
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_idle;
    // stage 0: video input
    logic s0_start;
    logic s0_ready;
    logic s0_done;
    logic s0_idle;
    // stage 1: processing loop
    logic s1_start;
    logic s1_ready;
    logic s1_done;
    logic s1_idle;
    // stage 2: video output
    logic s2_start;
    logic s2_ready;
    logic s2_done;
    logic s2_idle;

    // controller side
    modport master (
        input  ap_start,
        output ap_ready, ap_done, ap_idle,
        output s0_start, input s0_ready, s0_done, s0_idle,
        output s1_start, input s1_ready, s1_done, s1_idle,
        output s2_start, input s2_ready, s2_done, s2_idle
    );

    // environment / stage side
    modport slave (
        output ap_start,
        input  ap_ready, ap_done, ap_idle,
        input  s0_start, output s0_ready, s0_done, s0_idle,
        input  s1_start, output s1_ready, s1_done, s1_idle,
        input  s2_start, output s2_ready, s2_done, s2_idle
    );
endinterface

// File: rtl/vip_dataflow_ctrl.sv
// Dataflow controller for a three-stage video pipeline. Stages 0 and 1 are
// started together from ap_start; each start accepted by stage 1 becomes a
// token in a small start FIFO that launches stage 2. Also counts completed
// frames and flags a stall when no handshake activity happens for too long.
module vip_dataflow_ctrl #(
    parameter int START_FIFO_DEPTH = 2,
    parameter int FRAME_CNT_W      = 16,
    parameter int STALL_TIMEOUT    = 1024
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    vip_dataflow_if.master         bus,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   stall
);

    localparam int TCNT_W  = $clog2(START_FIFO_DEPTH + 1);
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0]  DEPTH   = TCNT_W'(START_FIFO_DEPTH);
    localparam logic [STALL_W-1:0] TIMEOUT = STALL_W'(STALL_TIMEOUT);

    logic               r0;
    logic               r1;
    logic [TCNT_W-1:0]  tcnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_cnt_next;
    logic               full;
    logic               push;
    logic               pop;
    logic               stall_clr;

    // Start gating, FIFO handshakes and status outputs are pure decode of state.
    assign full         = (tcnt == DEPTH);
    assign bus.ap_ready = (bus.s0_ready | r0) & (bus.s1_ready | r1);
    assign bus.s0_start = bus.ap_start & ~r0 & ~full;
    assign bus.s1_start = bus.ap_start & ~r1 & ~full;
    assign bus.s2_start = (tcnt != '0);
    assign push         = bus.s1_start & bus.s1_ready;
    assign pop          = bus.s2_start & bus.s2_ready;
    assign bus.ap_idle  = bus.s0_idle & bus.s1_idle & bus.s2_idle
                        & (tcnt == '0) & ~r0 & ~r1;
    assign stall_clr    = bus.ap_ready | push | pop
                        | bus.s0_done | bus.s1_done | bus.s2_done;

    // Remember which stage already reported ready until both have.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r0 <= 1'b0;
            r1 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            r0 <= ~bus.ap_ready & (r0 | bus.s0_ready);
            r1 <= ~bus.ap_ready & (r1 | bus.s1_ready);
        end
    end

    // Start-token occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tcnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   tcnt <= tcnt + 1'b1;
                2'b01:   tcnt <= tcnt - 1'b1;
                default: tcnt <= tcnt;
            endcase
        end
    end

    // Frame completion: delayed done pulse and wrapping frame counter.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            bus.ap_done <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            bus.ap_done <= bus.s2_done;
            if (bus.s2_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Watchdog next count: clear on activity or idle, else saturating count.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        stall_cnt_next = stall_cnt;
        if (stall_clr || bus.ap_idle) begin
            stall_cnt_next = '0;
        end else if (stall_cnt != TIMEOUT) begin
            stall_cnt_next = stall_cnt + 1'b1;
        end
    end

    // Watchdog registers; the flag tracks the counter reaching the limit.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stall_cnt <= '0;
            stall     <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            stall     <= (stall_cnt_next == TIMEOUT);
        end
    end

endmodule
